// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier. Operands arrive one after the other on
// inbus (multiplicand, then multiplier); signed or unsigned operation is
// chosen per run. Operands are widened by one bit so that the same Booth
// recoding covers both modes, at the cost of one extra iteration.
module booth_mul_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   inbus,
    output logic               ld_m,
    output logic               ld_q,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // state   | meaning
    // IDLE    | waiting for start (with enable)
    // LOAD_M  | capture multiplicand from inbus, clear accumulator
    // LOAD_Q  | capture multiplier from inbus
    // DECIDE  | inspect {Q[0],qm1} to choose add/sub or plain shift
    // ADDSUB  | A +/- M
    // SHIFT   | arithmetic right shift of {A,Q,qm1}; last one goes to OUT
    // INCR    | advance iteration counter
    // OUT     | latch product, pulse done

    localparam int W1 = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W1 - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_Q,
        DECIDE,
        ADDSUB,
        SHIFT,
        INCR,
        OUT
    } state_t;

    state_t               state_q, state_d;
    logic [W1-1:0]        a_q, a_d;
    logic [W1-1:0]        q_q, q_d;
    logic [W1-1:0]        m_q, m_d;
    logic                 qm1_q, qm1_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 mode_q, mode_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ld_m_q, ld_m_d;
    logic                 ld_q_q, ld_q_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Widen an operand by one bit; the extra bit is a sign copy only in signed mode.
    function automatic logic [W1-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
        return {sgn & v[WIDTH-1], v};
    endfunction

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        count_d   = count_q;
        mode_d    = mode_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start && enable) begin
                    state_d = LOAD_M;
                    mode_d  = signed_mode;
                end
            end
            LOAD_M: begin
                m_d     = extend(inbus, mode_q);
                a_d     = '0;
                qm1_d   = 1'b0;
                count_d = '0;
                state_d = LOAD_Q;
            end
            LOAD_Q: begin
                q_d     = extend(inbus, mode_q);
                state_d = DECIDE;
            end
            DECIDE: begin
                state_d = (q_q[0] ^ qm1_q) ? ADDSUB : SHIFT;
            end
            ADDSUB: begin
                // Only reached for pairs 10 (subtract) and 01 (add).
                a_d     = q_q[0] ? (a_q - m_q) : (a_q + m_q);
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d     = {a_q[W1-1], a_q[W1-1:1]};
                q_d     = {a_q[0], q_q[W1-1:1]};
                qm1_d   = q_q[0];
                state_d = (count_q == LAST_CNT) ? OUT : INCR;
            end
            INCR: begin
                count_d = count_q + CNT_W'(1);
                state_d = DECIDE;
            end
            OUT: begin
                // Low 2*WIDTH bits of {A,Q}; the top two bits of A are redundant.
                product_d = {a_q[WIDTH-2:0], q_q};
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Losing enable abandons the run from any active state.
        if ((state_q != IDLE) && !enable) begin
            state_d = IDLE;
        end

        // Outputs are registered from the next state so they track the state register exactly.
        ld_m_d = (state_d == LOAD_M);
        ld_q_d = (state_d == LOAD_Q);
        busy_d = (state_d != IDLE);
        done_d = (state_d == OUT);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            mode_q    <= 1'b0;
            product_q <= '0;
            ld_m_q    <= 1'b0;
            ld_q_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            product_q <= product_d;
            ld_m_q    <= ld_m_d;
            ld_q_q    <= ld_q_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ld_m    = ld_m_q;
    assign ld_q    = ld_q_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: three instances (WIDTH 4, 8, 16) share clock,
// reset, enable, signed_mode and inbus; each has its own start line.
module tb_booth_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        signed_mode;
    logic [15:0] inbus;
    logic [2:0]  start_v;
    logic [2:0]  ld_m_v;
    logic [2:0]  ld_q_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic [31:0] prod16;

    int tests = 0;
    int fails = 0;

    booth_mul_seq #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start_v[0]),
        .signed_mode(signed_mode), .inbus(inbus[3:0]),
        .ld_m(ld_m_v[0]), .ld_q(ld_q_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .product(prod4)
    );

    booth_mul_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start_v[1]),
        .signed_mode(signed_mode), .inbus(inbus[7:0]),
        .ld_m(ld_m_v[1]), .ld_q(ld_q_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .product(prod8)
    );

    booth_mul_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start_v[2]),
        .signed_mode(signed_mode), .inbus(inbus),
        .ld_m(ld_m_v[2]), .ld_q(ld_q_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .product(prod16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "timeout");
    end

    function automatic int w_of(input int idx);
        return (idx == 0) ? 4 : ((idx == 1) ? 8 : 16);
    endfunction

    function automatic logic [31:0] prod_of(input int idx);
        case (idx)
            0:       return {24'b0, prod4};
            1:       return {16'b0, prod8};
            default: return prod16;
        endcase
    endfunction

    // Operand value as an integer under the chosen interpretation.
    function automatic longint opval(input int w, input logic sm, input logic [31:0] v);
        longint x;
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (sm && x[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    function automatic logic [31:0] ref_product(input int w, input logic sm,
                                                input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = opval(w, sm, a) * opval(w, sm, b);
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    // Booth pairs (bit i, bit i-1) of the widened multiplier that differ need an add/sub.
    function automatic int ref_out_cycle(input int w, input logic sm, input logic [31:0] b);
        longint qe;
        longint mask;
        int     k;
        int     w1;
        w1   = w + 1;
        mask = (longint'(1) << w1) - 1;
        qe   = opval(w, sm, b) & mask;
        k    = $countones((qe ^ (qe << 1)) & mask);
        return 2 + 2 * w1 + (w1 - 1) + k + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a start and feed both operands; returns at the negedge of cycle 2.
    task automatic start_op(input int idx, input logic sm, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        enable       = 1'b1;
        signed_mode  = sm;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        chk("ld_m_cycle1", ld_m_v[idx], 1'b1);
        chk("busy_cycle1", busy_v[idx], 1'b1);
        inbus = a[15:0];
        @(negedge clk);
        chk("ld_q_cycle2", ld_q_v[idx], 1'b1);
        chk("ld_m_cycle2", ld_m_v[idx], 1'b0);
        inbus = b[15:0];
    endtask

    // Full run: operands, wait for done (bounded), check result, latency and quiet aftermath.
    task automatic do_mul(input int idx, input logic sm, input logic [31:0] a, input logic [31:0] b,
                          input bit spam, output int oc);
        int cyc;
        int limit;
        int w;
        bit seen;
        w     = w_of(idx);
        limit = 4 * (w + 1) + 10;
        cyc   = 2;
        seen  = 1'b0;
        oc    = -1;
        start_op(idx, sm, a, b);
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            chk("busy_run", busy_v[idx], 1'b1);
            if (done_v[idx]) begin
                seen         = 1'b1;
                oc           = cyc;
                start_v[idx] = 1'b0;
            end else begin
                if (spam) start_v[idx] = 1'($urandom_range(0, 1));
                signed_mode = 1'($urandom_range(0, 1));
            end
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("out_cycle", oc, ref_out_cycle(w, sm, a) == 0 ? 0 : ref_out_cycle(w, sm, b));
        @(negedge clk);
        chk("product", prod_of(idx), ref_product(w, sm, a, b));
        chk("done_after", done_v[idx], 1'b0);
        chk("busy_after", busy_v[idx], 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_done", done_v[idx], 1'b0);
            chk("idle_busy", busy_v[idx], 1'b0);
        end
    endtask

    initial begin
        int oc;
        rst_n       = 1'b0;
        enable      = 1'b0;
        signed_mode = 1'b0;
        inbus       = '0;
        start_v     = '0;
        #1;
        chk("rst_product", prod_of(1), 32'h0);
        chk("rst_busy", {29'b0, busy_v}, 32'h0);
        chk("rst_done", {29'b0, done_v}, 32'h0);
        chk("rst_ld", {26'b0, ld_m_v, ld_q_v}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // enable low blocks start in IDLE
        @(negedge clk);
        start_v[1] = 1'b1;
        enable     = 1'b0;
        @(negedge clk);
        chk("no_start_enable0", busy_v[1], 1'b0);
        start_v[1] = 1'b0;

        do_mul(1, 1'b1, 32'hFD, 32'h05, 1'b0, oc);
        chk("neg3_times5", prod_of(1), 32'hFFF1);
        do_mul(1, 1'b0, 32'hFF, 32'hFF, 1'b0, oc);
        chk("u255_sq", prod_of(1), 32'hFE01);
        do_mul(1, 1'b1, 32'hFF, 32'hFF, 1'b0, oc);
        chk("s255_sq", prod_of(1), 32'h0001);
        do_mul(1, 1'b1, 32'h80, 32'h80, 1'b0, oc);
        chk("m128_sq", prod_of(1), 32'h4000);
        do_mul(1, 1'b1, 32'h00, 32'h00, 1'b0, oc);
        chk("zero_out_cycle", oc, 32'd29);
        do_mul(1, 1'b1, 32'h80, 32'h80, 1'b1, oc);
        chk("m128_spam", prod_of(1), 32'h4000);

        // Abort with enable during the 4th SHIFT (cycle 13 when the multiplier is 0).
        start_op(1, 1'b1, 32'h05, 32'h00);
        repeat (11) begin
            @(negedge clk);
            chk("abort_busy", busy_v[1], 1'b1);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy_v[1], 1'b0);
        chk("abort_done", done_v[1], 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", done_v[1], 1'b0);
        end
        chk("abort_product_held", prod_of(1), 32'h4000);
        do_mul(1, 1'b0, 32'h9C, 32'h37, 1'b0, oc);

        // Reset during the first ADDSUB (cycle 4 for multiplier 1).
        do_mul(1, 1'b0, 32'hFF, 32'hFF, 1'b0, oc);
        start_op(1, 1'b1, 32'h03, 32'h01);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy_v[1], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_v[1], 1'b0);
        chk("mid_rst_done", done_v[1], 1'b0);
        chk("mid_rst_ld", {30'b0, ld_m_v[1], ld_q_v[1]}, 32'h0);
        chk("mid_rst_product", prod_of(1), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_done", done_v[1], 1'b0);
        end
        do_mul(1, 1'b1, 32'hFD, 32'h05, 1'b0, oc);
        chk("post_rst_result", prod_of(1), 32'hFFF1);

        // Random sweep across all three widths, with stray start pulses while busy.
        for (int idx = 0; idx < 3; idx++) begin
            for (int n = 0; n < 20; n++) begin
                do_mul(idx, 1'($urandom_range(0, 1)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), oc);
            end
        end
        do_mul(0, 1'b1, 32'h8, 32'h8, 1'b0, oc);
        chk("w4_min_sq", prod_of(0), 32'h40);
        do_mul(2, 1'b1, 32'h8000, 32'h7FFF, 1'b0, oc);
        chk("w16_min_max", prod_of(2), 32'hC0008000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
